// File: rtl/mouse_joy_pkg.sv
// mouse_joy_pkg
// Shared definitions for the mouse-as-joystick emulator: the BBC ADC centre
// value, the 8-bit position limits, the source-select enum and the mapping
// from a signed stick position to the 12-bit ADC reading the core expects.
package mouse_joy_pkg;

  localparam logic [11:0]       ADC_CENTRE = 12'h7F7;
  localparam logic signed [7:0] POS_MIN    = 8'sh80;
  localparam logic signed [7:0] POS_MAX    = 8'sh7F;

  typedef enum logic {
    SRC_JOY   = 1'b0,
    SRC_MOUSE = 1'b1
  } src_t;

  // The BBC ADC reads high for left/up, so the offset-binary position is
  // inverted. The low nibble repeats the top nibble to fill 12 bits.
  function automatic logic [11:0] adc12(input logic signed [7:0] v);
    logic [7:0] a8;
    a8 = 8'hFF - {~v[7], v[6:0]};
    return {a8, a8[7:4]};
  endfunction

endpackage

// File: rtl/mouse_axis.sv
// mouse_axis
// One emulated stick axis. Turns a raw 9-bit PS/2 delta into a clamped step
// and accumulates it into a saturating 8-bit signed position.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   sign_i, mag_i   raw delta as {sign, byte}
//   apply_i         add this cycle's delta to the position
//   zero_i          force the position to 0 (wins over everything)
//   decay_i         move the position 1 step toward 0
//   pos_o           current signed position
module mouse_axis
  import mouse_joy_pkg::*;
#(
  parameter int DELTA_SHIFT = 1,
  parameter int MAX_STEP    = 10,
  parameter bit INVERT      = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sign_i,
  input  logic [7:0]        mag_i,
  input  logic              apply_i,
  input  logic              zero_i,
  input  logic              decay_i,
  output logic signed [7:0] pos_o
);

  localparam logic signed [8:0] STEP_HI = 9'(MAX_STEP);
  localparam logic signed [8:0] STEP_LO = -STEP_HI;
  localparam logic signed [9:0] SUM_HI  = 10'(POS_MAX);
  localparam logic signed [9:0] SUM_LO  = 10'(POS_MIN);

  logic signed [8:0] raw;
  logic signed [8:0] shifted;
  logic signed [8:0] step;
  logic signed [9:0] base;
  logic signed [9:0] delta;
  logic signed [9:0] sum;
  logic signed [7:0] sat;
  logic signed [7:0] pos_q;
  logic signed [7:0] pos_d;

  // The 10-bit sum cannot overflow (|pos| <= 128, |step| <= MAX_STEP), so
  // saturation only has to compare against the 8-bit limits. Y is inverted
  // because mouse-up must push the stick up, which is a negative position.
  always_comb begin
    raw     = $signed({sign_i, mag_i});
    shifted = raw >>> DELTA_SHIFT;
    if (shifted > STEP_HI) begin
      step = STEP_HI;
    end else if (shifted < STEP_LO) begin
      step = STEP_LO;
    end else begin
      step = shifted;
    end
    base  = 10'(pos_q);
    delta = 10'(step);
    sum   = INVERT ? (base - delta) : (base + delta);
    if (sum > SUM_HI) begin
      sat = POS_MAX;
    end else if (sum < SUM_LO) begin
      sat = POS_MIN;
    end else begin
      sat = sum[7:0];
    end

    pos_d = pos_q;
    if (zero_i) begin
      pos_d = '0;
    end else if (apply_i) begin
      pos_d = sat;
    end else if (decay_i) begin
      if (pos_q > 8'sd0) begin
        pos_d = pos_q - 8'sd1;
      end else if (pos_q < 8'sd0) begin
        pos_d = pos_q + 8'sd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/mouse_joy_emu.sv
// mouse_joy_emu
// Feeds the BBC joystick ADC inputs either from the host analog joystick or
// from a PS/2 mouse emulating a self-centring stick.
// Ports:
//   clk_sys, reset_n    system clock, async active-low reset
//   enable              mouse may take over the joystick
//   clear               synchronous return to joystick source, positions 0
//   ps2_mouse[24:0]     toggle strobe, dy, dx, signs, buttons
//   joy_digital[15:0]   host digital joystick; any bit set = joystick in use
//   joy_x, joy_y        host analog axes, signed
//   adc_x, adc_y        12-bit ADC readings
//   fire_n              active-low fire
//   mouse_active        mouse is the current source
module mouse_joy_emu
  import mouse_joy_pkg::*;
#(
  parameter int DELTA_SHIFT   = 1,
  parameter int MAX_STEP      = 10,
  parameter int RECENTER_IDLE = 0,
  parameter int DECAY_DIV     = 65536
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joy_digital,
  input  logic [7:0]  joy_x,
  input  logic [7:0]  joy_y,
  output logic [11:0] adc_x,
  output logic [11:0] adc_y,
  output logic        fire_n,
  output logic        mouse_active
);

  localparam int IDLE_W = (RECENTER_IDLE > 0) ? $clog2(RECENTER_IDLE + 1) : 1;
  localparam int DIV_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [IDLE_W-1:0] IDLE_SAT    = IDLE_W'(RECENTER_IDLE);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(DECAY_DIV - 1);
  localparam bit                RECENTRE_ON = (RECENTER_IDLE > 0);

  logic              strobe_q;
  src_t              src_q;
  src_t              src_d;
  logic [IDLE_W-1:0] idleCnt_q;
  logic [IDLE_W-1:0] idleCnt_d;
  logic [DIV_W-1:0]  divCnt_q;
  logic [DIV_W-1:0]  divCnt_d;
  logic [11:0]       adcX_q;
  logic [11:0]       adcY_q;
  logic              fireN_q;
  logic              mouseActive_q;

  logic              packetEvent;
  logic              zeroPos;
  logic              applyPkt;
  logic              decayTick;
  logic signed [7:0] posX;
  logic signed [7:0] posY;
  logic              unusedBits;

  assign unusedBits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  // Source arbitration. Anything that hands control back to the joystick
  // also zeroes the positions and outranks a packet arriving the same cycle.
  // A packet seen while on the joystick switches to the mouse and is applied
  // on that same edge, starting from the zeroed position.
  // The idle/decay counters only run while the mouse stays the source; a
  // packet restarts the idle wait and suppresses any decay step that cycle.
  always_comb begin
    packetEvent = ps2_mouse[24] ^ strobe_q;
    zeroPos     = clear | ~enable | (|joy_digital);
    applyPkt    = packetEvent & ~zeroPos;

    src_d = src_q;
    if (zeroPos) begin
      src_d = SRC_JOY;
    end else if (packetEvent) begin
      src_d = SRC_MOUSE;
    end

    idleCnt_d = '0;
    divCnt_d  = '0;
    decayTick = 1'b0;
    if (RECENTRE_ON && (src_q == SRC_MOUSE) && (src_d == SRC_MOUSE) && !packetEvent) begin
      if (idleCnt_q != IDLE_SAT) begin
        idleCnt_d = idleCnt_q + 1'b1;
      end else begin
        idleCnt_d = idleCnt_q;
        if (divCnt_q == DIV_LAST) begin
          decayTick = 1'b1;
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
    end
  end

  mouse_axis #(
    .DELTA_SHIFT (DELTA_SHIFT),
    .MAX_STEP    (MAX_STEP),
    .INVERT      (1'b0)
  ) uAxisX (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .sign_i  (ps2_mouse[4]),
    .mag_i   (ps2_mouse[15:8]),
    .apply_i (applyPkt),
    .zero_i  (zeroPos),
    .decay_i (decayTick),
    .pos_o   (posX)
  );

  mouse_axis #(
    .DELTA_SHIFT (DELTA_SHIFT),
    .MAX_STEP    (MAX_STEP),
    .INVERT      (1'b1)
  ) uAxisY (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .sign_i  (ps2_mouse[5]),
    .mag_i   (ps2_mouse[23:16]),
    .apply_i (applyPkt),
    .zero_i  (zeroPos),
    .decay_i (decayTick),
    .pos_o   (posY)
  );

  // Source FSM plus the output registers. Outputs are built from the
  // registered source and positions, so a position change shows on the ADC
  // exactly one cycle after the edge that updated it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q      <= 1'b0;
      src_q         <= SRC_JOY;
      idleCnt_q     <= '0;
      divCnt_q      <= '0;
      adcX_q        <= ADC_CENTRE;
      adcY_q        <= ADC_CENTRE;
      fireN_q       <= 1'b1;
      mouseActive_q <= 1'b0;
    end else begin
      strobe_q  <= ps2_mouse[24];
      src_q     <= src_d;
      idleCnt_q <= idleCnt_d;
      divCnt_q  <= divCnt_d;
      if (src_q == SRC_MOUSE) begin
        adcX_q  <= adc12(posX);
        adcY_q  <= adc12(posY);
        fireN_q <= ~|ps2_mouse[1:0];
      end else begin
        adcX_q  <= adc12(joy_x);
        adcY_q  <= adc12(joy_y);
        fireN_q <= ~joy_digital[4];
      end
      mouseActive_q <= (src_q == SRC_MOUSE);
    end
  end

  assign adc_x        = adcX_q;
  assign adc_y        = adcY_q;
  assign fire_n       = fireN_q;
  assign mouse_active = mouseActive_q;

endmodule
